// File: rtl/gray_ptr_sync_pkg.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync_pkg
// Purpose : Shared definitions for the Gray-pointer synchroniser slice.
//           FSM state encodings and default widths/stage counts.
// Contents: DEF_DATA_WIDTH, DEF_SYNC_STAGES, sync_state_t (ST_PRIME, ST_RUN)
// -----------------------------------------------------------------------------
package gray_ptr_sync_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } sync_state_t;

endpackage

// File: rtl/gray_ptr_sync_gray2bin.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync_gray2bin
// Purpose : Purely combinational Gray-to-binary converter, width-parameterised.
//           Reusable on any Gray pointer (e.g. the FIFO read side).
// Ports   : i_gray [DATA_WIDTH-1:0]  Gray-coded input
//           o_bin  [DATA_WIDTH-1:0]  binary equivalent
// -----------------------------------------------------------------------------
module gray_ptr_sync_gray2bin
  import gray_ptr_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_gray,
  output logic [DATA_WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it. Written as a
  // reduction per bit rather than a ripple over o_bin so no net feeds itself.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[DATA_WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_ptr_sync.sv
// -----------------------------------------------------------------------------
// gray_ptr_sync
// Purpose : Brings a Gray-coded count from a foreign clock domain into clk,
//           converts it to binary and reports the per-sample increment.
//           Optional sticky flag for illegal multi-bit Gray transitions,
//           enabled by defining the macro GRAY_SYNC_ERR_CHECK_EN.
// Ports   : clk          destination-domain clock
//           rst_n        asynchronous, active-low reset
//           gray_in      Gray count from the source domain (async to clk)
//           clr          synchronous re-baseline request (ignored while priming)
//           ready_out    high once the synchroniser is primed
//           binary_out   synchronised count, binary
//           delta_out    binary_out minus previous binary_out, modulo 2^N
//           change_strb  one-cycle pulse when delta_out != 0
//           err_out      sticky multi-bit-transition flag (0 when check disabled)
// -----------------------------------------------------------------------------
module gray_ptr_sync
  import gray_ptr_sync_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gray_in,
  input  logic                  clr,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] binary_out,
  output logic [DATA_WIDTH-1:0] delta_out,
  output logic                  change_strb,
  output logic                  err_out
);

  localparam int                CNT_W      = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain: element 0 captures gray_in, last element is g_s.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  w_g_s;
  logic [DATA_WIDTH-1:0]                  w_b_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], gray_in};
    end
  end

  assign w_g_s = r_sync[SYNC_STAGES-1];

  gray_ptr_sync_gray2bin #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_gray2bin (
    .i_gray (w_g_s),
    .o_bin  (w_b_s)
  );

  // ---------------------------------------------------------------------------
  // Prime counter / FSM and output registers.
  // The counter walks 0..SYNC_STAGES after reset release; the cycle where it
  // reaches SYNC_STAGES is the baseline cycle, by which time the value held on
  // gray_in has travelled through every synchroniser stage. Loading the
  // baseline there gives a zero delta rather than a spurious jump from 0.
  // ---------------------------------------------------------------------------
  sync_state_t           r_state;
  logic [CNT_W-1:0]      r_prime_cnt;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_bin;
  logic [DATA_WIDTH-1:0] r_delta;
  logic                  r_strb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_PRIME;
      r_prime_cnt <= '0;
      r_ready     <= 1'b0;
      r_bin       <= '0;
      r_delta     <= '0;
      r_strb      <= 1'b0;
    end else begin
      case (r_state)
        ST_PRIME: begin
          if (r_prime_cnt == PRIME_LAST) begin
            r_bin   <= w_b_s;
            r_delta <= '0;
            r_strb  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_prime_cnt <= r_prime_cnt + CNT_ONE;
          end
        end
        ST_RUN: begin
          r_bin <= w_b_s;
          // clr re-baselines: the new sample is accepted without a delta.
          if (clr) begin
            r_delta <= '0;
            r_strb  <= 1'b0;
          end else begin
            r_delta <= w_b_s - r_bin;  // modulo 2^N, handles wrap and down-count
            r_strb  <= (w_b_s != r_bin);
          end
        end
        default: begin
          r_state <= ST_PRIME;
        end
      endcase
    end
  end

  assign ready_out   = r_ready;
  assign binary_out  = r_bin;
  assign delta_out   = r_delta;
  assign change_strb = r_strb;

  // ---------------------------------------------------------------------------
  // Optional multi-bit transition check.
  // ---------------------------------------------------------------------------
`ifdef GRAY_SYNC_ERR_CHECK_EN
  logic [DATA_WIDTH-1:0] r_g_prev;
  logic [DATA_WIDTH-1:0] w_g_diff;
  logic                  w_multi_bit;
  logic                  r_err;

  assign w_g_diff = w_g_s ^ r_g_prev;
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi_bit = (w_g_diff & (w_g_diff - DATA_WIDTH'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_prev <= '0;
      r_err    <= 1'b0;
    end else begin
      // Tracked every cycle so the first RUN comparison is against the
      // baseline sample; the flag itself only moves in RUN.
      r_g_prev <= w_g_s;
      if (r_state == ST_RUN) begin
        if (clr) begin
          r_err <= 1'b0;
        end else if (w_multi_bit) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign err_out = r_err;
`else
  assign err_out = 1'b0;
`endif

endmodule
